fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 3-stage pipelined processor. It sits directly upstream of the first control-capture pipeline register.
- Owns the program counter and drives the program-memory address. It registers each 16-bit instruction word as `segment`, together with the evaluated branch-condition flag `FL` and the next-PC value `PC_in`.
- Handles PC redirects from the execute-stage control (`L_PC` plus the MUX1-selected target), inserts NOP bubbles after a redirect, and supports pipeline stall.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- FLUSH_SLOTS, 2, number of NOP words (16'h0000) emitted per redirect; legal range 1..7.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  8  program-memory address; always equals the PC register.
- imem_data  input  16  program-memory read data; combinational (same-cycle) read of imem_addr.
- L_PC  input  1  PC load strobe from stage-3 control.
- pc_target  input  8  redirect target, valid while L_PC=1.
- stall  input  1  hold request from downstream.
- flags_in  input  4  architectural flags {P,S,Z,C}.
- segment  output  16  registered instruction word; [15:8] is the opcode, [7:0] is the operand.
- FL  output  1  registered condition result for the instruction in `segment`.
- PC_in  output  8  registered address of the instruction in `segment`, plus 1.

Behaviour:
- Reset (async, immediate): PC=RESET_PC; segment=16'h0000; FL=0; PC_in=8'h00; flush counter=0; state=RUN. The first rising edge after rst deasserts captures imem[RESET_PC].
- States:
  - RUN: normal fetch.
  - FLUSH: emitting bubbles, with a 3-bit counter holding the bubbles remaining.
- Priority at each rising edge: rst > L_PC > stall > normal operation.
- RUN, no stall, no L_PC:
  - segment <= imem_data.
  - PC_in <= PC+1.
  - FL <= flags_in[imem_data[9:8]] XOR imem_data[10].
  - PC <= PC+1.
  - Latency: the word at address A appears on segment exactly 1 edge after PC=A.
- L_PC=1 (any state, stall ignored):
  - PC <= pc_target.
  - segment <= 16'h0000; FL <= 0; PC_in <= 8'h00.
  - If FLUSH_SLOTS>1: state <= FLUSH with counter <= FLUSH_SLOTS-1. Otherwise state stays RUN.
- FLUSH, no stall, no L_PC:
  - segment <= 16'h0000; FL <= 0; PC_in <= 8'h00.
  - PC holds.
  - Counter decrements; when the counter reaches 0 on this edge, state <= RUN.
  - The target instruction is captured on the first RUN edge.
- stall=1, no L_PC: PC, segment, FL, PC_in, counter and state all hold.
- L_PC during FLUSH: the redirect restarts, with the counter reloaded to FLUSH_SLOTS-1 and PC loaded with the new target.
- PC arithmetic is modulo 256:
  - PC=8'hFF advances to 8'h00.
  - PC_in for the instruction at address 8'hFF is 8'h00.
- FL is computed from flags_in sampled at the capture edge. Opcode decoding is left to the control stages.
- imem_addr is combinational from the PC register only; no path from any input.
- Reset asserted mid-FLUSH clears the counter and state immediately; fetch resumes from RESET_PC.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds two output ports, both cleared by rst and saturating at 16'hFFFF:
  - fetch_cnt (16 bits): increments on every RUN-state capture edge that is not stalled.
  - bubble_cnt (16 bits): increments on every edge that emits a redirect or FLUSH bubble.
- When undefined, the ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then sequential run: imem[n]=16'h1100+n, rst pulsed, 4 free edges -> segment = 16'h1100..16'h1103 on edges 1..4; PC_in = 01..04; imem_addr=04 after edge 4.
- Redirect, FLUSH_SLOTS=2: L_PC=1 with pc_target=8'h40 at an edge while PC=05 -> that edge and the next give segment=0000 and FL=0; the third edge gives segment=imem[40] and PC_in=41.
- Stall versus redirect: stall=1 for 3 edges -> all outputs frozen and imem_addr constant. Then stall=1 with L_PC=1 and pc_target=8'h80 -> PC=80 and a bubble is emitted (L_PC wins).
- Flag evaluation: flags_in=4'b0010 (Z=1), imem_data=16'h0900 (sel=01, invert=0) -> FL=1 at capture. With imem_data=16'h0D00 (invert=1) -> FL=0.
- Wrap: PC=8'hFF, free edge -> segment=imem[FF], PC_in=00, imem_addr=00.
- Reset mid-FLUSH: rst asserted between edges while the counter is 1 -> outputs zero immediately. After release, the first edge captures imem[RESET_PC]. With FETCH_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: program-memory port, redirect/stall control, and the captured segment.
// Latency: none; wiring only.
// Backpressure: 'stall' travels from the downstream side into the fetch stage.
interface fetch_stage_if;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        L_PC;
  logic [7:0]  pc_target;
  logic        stall;
  logic [3:0]  flags_in;
  logic [15:0] segment;
  logic        FL;
  logic [7:0]  PC_in;

  // Fetch stage side: drives the memory address and the captured pipeline register.
  modport master (
    output imem_addr,
    input  imem_data,
    input  L_PC,
    input  pc_target,
    input  stall,
    input  flags_in,
    output segment,
    output FL,
    output PC_in
  );

  // Environment side: program memory, execute-stage control and the downstream register.
  modport slave (
    input  imem_addr,
    output imem_data,
    output L_PC,
    output pc_target,
    output stall,
    output flags_in,
    input  segment,
    input  FL,
    input  PC_in
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, captures imem word + condition flag + PC+1; NOP bubbles follow a redirect.
// Latency: the word at address A is on 'segment' one edge after PC=A; a redirect costs FLUSH_SLOTS bubbles.
// Backpressure: stall freezes every register; a redirect (L_PC) overrides stall. FETCH_PERF_CNT_EN adds perf counters.
module fetch_stage #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter int         FLUSH_SLOTS = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]   fetch_cnt,
  output logic [15:0]   bubble_cnt
`endif
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_SLOTS - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] seg_q, seg_d;
  logic        fl_q, fl_d;
  logic [7:0]  pcin_q, pcin_d;
  logic [7:0]  pc_inc;
  logic        cond;
  logic        fetch_edge;
  logic        bubble_edge;

  assign pc_inc = pc_q + 8'd1;
  // Condition select picks one of {P,S,Z,C}; bit 10 inverts the sense.
  assign cond   = bus.flags_in[bus.imem_data[9:8]] ^ bus.imem_data[10];

  assign bus.imem_addr = pc_q;
  assign bus.segment   = seg_q;
  assign bus.FL        = fl_q;
  assign bus.PC_in     = pcin_q;

  // Next-state and next-register values: redirect beats stall beats normal fetch/flush.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    seg_d       = seg_q;
    fl_d        = fl_q;
    pcin_d      = pcin_q;
    fetch_edge  = 1'b0;
    bubble_edge = 1'b0;
    if (bus.L_PC) begin
      pc_d        = bus.pc_target;
      seg_d       = 16'h0000;
      fl_d        = 1'b0;
      pcin_d      = 8'h00;
      bubble_edge = 1'b1;
      if (FLUSH_SLOTS > 1) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_LOAD;
      end else begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    end else if (!bus.stall) begin
      case (state_q)
        RUN: begin
          seg_d      = bus.imem_data;
          pcin_d     = pc_inc;
          fl_d       = cond;
          pc_d       = pc_inc;
          fetch_edge = 1'b1;
        end
        FLUSH: begin
          seg_d       = 16'h0000;
          fl_d        = 1'b0;
          pcin_d      = 8'h00;
          bubble_edge = 1'b1;
          cnt_d       = cnt_q - 3'd1;
          if (cnt_d == 3'd0) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Pipeline register, PC and flush bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
      pc_q    <= RESET_PC;
      seg_q   <= 16'h0000;
      fl_q    <= 1'b0;
      pcin_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      seg_q   <= seg_d;
      fl_q    <= fl_d;
      pcin_q  <= pcin_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters of real fetches and of emitted bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt  <= 16'h0000;
      bubble_cnt <= 16'h0000;
    end else begin
      if (fetch_edge && fetch_cnt != 16'hFFFF)   fetch_cnt  <= fetch_cnt + 16'd1;
      if (bubble_edge && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = fetch_edge ^ bubble_edge;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential run, redirect, stall, flags, wrap, reset mid-flush.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: stall and stall-vs-redirect are exercised directly.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] mem [256];

  fetch_stage_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt, bubble_cnt;
  fetch_stage #(.RESET_PC(8'h00), .FLUSH_SLOTS(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt));
`else
  fetch_stage #(.RESET_PC(8'h00), .FLUSH_SLOTS(2)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Combinational program memory.
  always_comb bus.imem_data = mem[bus.imem_addr];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] seg, input logic fl,
                         input logic [7:0] pcin, input logic [7:0] addr);
    check({tag, ".segment"}, bus.segment, seg);
    check({tag, ".FL"}, {15'd0, bus.FL}, {15'd0, fl});
    check({tag, ".PC_in"}, {8'd0, bus.PC_in}, {8'd0, pcin});
    check({tag, ".imem_addr"}, {8'd0, bus.imem_addr}, {8'd0, addr});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1100 + 16'(i);
    mem[8'h80] = 16'h0900;
    mem[8'h81] = 16'h0D00;
    bus.L_PC      = 1'b0;
    bus.pc_target = 8'h00;
    bus.stall     = 1'b0;
    bus.flags_in  = 4'b0000;

    #3;
    chk_out("reset", 16'h0000, 1'b0, 8'h00, 8'h00);
`ifdef FETCH_PERF_CNT_EN
    check("reset.fetch_cnt", fetch_cnt, 16'h0000);
    check("reset.bubble_cnt", bubble_cnt, 16'h0000);
`endif
    #4 rst = 1'b0;

    // Sequential run: words 1100..1104 on edges 1..5.
    step(); chk_out("seq1", 16'h1100, 1'b0, 8'h01, 8'h01);
    step(); chk_out("seq2", 16'h1101, 1'b0, 8'h02, 8'h02);
    step(); chk_out("seq3", 16'h1102, 1'b0, 8'h03, 8'h03);
    step(); chk_out("seq4", 16'h1103, 1'b0, 8'h04, 8'h04);
    step(); chk_out("seq5", 16'h1104, 1'b0, 8'h05, 8'h05);

    // Redirect to 40 while PC=05: two bubbles, then imem[40].
    bus.L_PC = 1'b1; bus.pc_target = 8'h40;
    step(); chk_out("redir_b1", 16'h0000, 1'b0, 8'h00, 8'h40);
    bus.L_PC = 1'b0;
    step(); chk_out("redir_b2", 16'h0000, 1'b0, 8'h00, 8'h40);
    step(); chk_out("redir_tgt", 16'h1140, 1'b0, 8'h41, 8'h41);

    // Stall three edges: everything frozen.
    bus.stall = 1'b1;
    step(); chk_out("stall1", 16'h1140, 1'b0, 8'h41, 8'h41);
    step(); chk_out("stall2", 16'h1140, 1'b0, 8'h41, 8'h41);
    step(); chk_out("stall3", 16'h1140, 1'b0, 8'h41, 8'h41);

    // Stall together with a redirect: the redirect wins.
    bus.L_PC = 1'b1; bus.pc_target = 8'h80;
    step(); chk_out("stall_redir", 16'h0000, 1'b0, 8'h00, 8'h80);
    bus.L_PC = 1'b0; bus.stall = 1'b0;
    step(); chk_out("stall_redir_b2", 16'h0000, 1'b0, 8'h00, 8'h80);

    // Flag evaluation with Z=1.
    bus.flags_in = 4'b0010;
    step(); chk_out("flag_true", 16'h0900, 1'b1, 8'h81, 8'h81);
    step(); chk_out("flag_inv", 16'h0D00, 1'b0, 8'h82, 8'h82);

    // Wrap at FF.
    bus.L_PC = 1'b1; bus.pc_target = 8'hFF;
    step(); chk_out("wrap_b1", 16'h0000, 1'b0, 8'h00, 8'hFF);
    bus.L_PC = 1'b0;
    step(); chk_out("wrap_b2", 16'h0000, 1'b0, 8'h00, 8'hFF);
    step(); chk_out("wrap", 16'h11FF, 1'b1, 8'h00, 8'h00);

`ifdef FETCH_PERF_CNT_EN
    check("perf.fetch_cnt", fetch_cnt, 16'd9);
    check("perf.bubble_cnt", bubble_cnt, 16'd6);
`endif

    // Reset in the middle of a flush (counter = 1).
    bus.L_PC = 1'b1; bus.pc_target = 8'h10;
    step(); chk_out("mid_b1", 16'h0000, 1'b0, 8'h00, 8'h10);
    bus.L_PC = 1'b0;
    #2 rst = 1'b1;
    #1 chk_out("mid_rst", 16'h0000, 1'b0, 8'h00, 8'h00);
`ifdef FETCH_PERF_CNT_EN
    check("mid_rst.fetch_cnt", fetch_cnt, 16'h0000);
    check("mid_rst.bubble_cnt", bubble_cnt, 16'h0000);
`endif
    #2 rst = 1'b0;
    step(); chk_out("post_rst", 16'h1100, 1'b1, 8'h01, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
